// File: rtl/simplebus_arbiter.sv
// N-to-1 SimpleBus arbiter: one grant per transaction, held through burst beats and the response.
// Define SIMPLEBUS_ARB_RR_EN for round-robin priority; otherwise fixed priority with master 0 highest.
module simplebus_arbiter #(
  parameter int N_MASTERS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_MASTERS-1:0]      m_req_valid,
  output logic [N_MASTERS-1:0]      m_req_ready,
  input  logic [N_MASTERS*127-1:0]  m_req_bits,
  output logic [N_MASTERS-1:0]      m_resp_valid,
  input  logic [N_MASTERS-1:0]      m_resp_ready,
  output logic [N_MASTERS*84-1:0]   m_resp_bits,
  output logic                      s_req_valid,
  input  logic                      s_req_ready,
  output logic [126:0]              s_req_bits,
  input  logic                      s_resp_valid,
  output logic                      s_resp_ready,
  input  logic [83:0]               s_resp_bits,
  output logic                      err
);
  localparam int IDX_W = $clog2(N_MASTERS);

  localparam logic [3:0] CMD_READ        = 4'b0000;
  localparam logic [3:0] CMD_WRITE       = 4'b0001;
  localparam logic [3:0] CMD_READ_BURST  = 4'b0010;
  localparam logic [3:0] CMD_WRITE_BURST = 4'b0011;
  localparam logic [3:0] CMD_PREFETCH    = 4'b0100;
  localparam logic [3:0] CMD_READ_LAST   = 4'b0110;
  localparam logic [3:0] CMD_WRITE_LAST  = 4'b0111;
  localparam logic [3:0] CMD_PROBE       = 4'b1000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_DATA = 2'd1,
    WAIT_RESP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               lock_q, lock_d;
  logic               rd_burst_q, rd_burst_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   grant_s, search_start_s;
  logic [126:0]       sel_bits_s;
  logic               sel_valid_s;
  logic [3:0]         sel_cmd_s;
  logic               accept_s;
  logic               s_req_valid_s, s_resp_ready_s;
  logic [N_MASTERS-1:0] m_req_ready_s, m_resp_valid_s;

  // First requesting master at or after start, wrapping; returns start when nobody requests.
  function automatic logic [IDX_W-1:0] first_valid(input logic [N_MASTERS-1:0] valid,
                                                   input logic [IDX_W-1:0]     start);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = (int'(start) + k) % N_MASTERS;
      if (!found && valid[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef SIMPLEBUS_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  assign search_start_s = ptr_q;

  // Pointer moves past the winner on the first accepted request of each transaction.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && accept_s) begin
      ptr_d = (grant_s == IDX_W'(N_MASTERS - 1)) ? {IDX_W{1'b0}} : grant_s + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= {IDX_W{1'b0}};
    else       ptr_q <= ptr_d;
  end
`else
  assign search_start_s = {IDX_W{1'b0}};
`endif

  // Grant selection: held owner during a transaction or a pending un-accepted request.
  always_comb begin
    if (state_q != IDLE || lock_q) grant_s = owner_q;
    else                           grant_s = first_valid(m_req_valid, search_start_s);
    sel_bits_s = m_req_bits[126:0];
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant_s == IDX_W'(i)) sel_bits_s = m_req_bits[i*127 +: 127];
      else                      sel_bits_s = sel_bits_s;
    end
  end

  assign sel_valid_s = m_req_valid[grant_s];
  assign sel_cmd_s   = sel_bits_s[91:88];

  // Transaction FSM, handshake routing and sticky error.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    lock_d         = lock_q;
    rd_burst_d     = rd_burst_q;
    err_d          = err_q;
    s_req_valid_s  = 1'b0;
    m_req_ready_s  = {N_MASTERS{1'b0}};
    m_resp_valid_s = {N_MASTERS{1'b0}};
    s_resp_ready_s = 1'b1;
    accept_s       = 1'b0;
    case (state_q)
      IDLE: begin
        s_req_valid_s          = sel_valid_s;
        m_req_ready_s[grant_s] = s_req_ready;
        accept_s               = sel_valid_s & s_req_ready;
        err_d                  = err_q | s_resp_valid;
        if (accept_s) begin
          owner_d    = grant_s;
          lock_d     = 1'b0;
          rd_burst_d = (sel_cmd_s == CMD_READ_BURST);
          if (sel_cmd_s == CMD_WRITE_BURST) begin
            state_d = WRITE_DATA;
          end else if (sel_cmd_s == CMD_READ || sel_cmd_s == CMD_READ_BURST ||
                       sel_cmd_s == CMD_PREFETCH || sel_cmd_s == CMD_PROBE ||
                       sel_cmd_s == CMD_WRITE) begin
            state_d = WAIT_RESP;
          end else begin
            state_d = IDLE;
          end
        end else if (sel_valid_s) begin
          owner_d = grant_s;
          lock_d  = 1'b1;
        end else begin
          lock_d  = lock_q;
        end
      end
      WRITE_DATA: begin
        s_req_valid_s          = sel_valid_s;
        m_req_ready_s[grant_s] = s_req_ready;
        accept_s               = sel_valid_s & s_req_ready;
        err_d                  = err_q | s_resp_valid;
        if (accept_s && sel_cmd_s == CMD_WRITE_LAST) state_d = WAIT_RESP;
        else                                         state_d = WRITE_DATA;
      end
      WAIT_RESP: begin
        m_resp_valid_s[owner_q] = s_resp_valid;
        s_resp_ready_s          = m_resp_ready[owner_q];
        // A burst read only completes on READ_LAST; anything else ends on its first response.
        if (s_resp_valid && s_resp_ready_s &&
            (!rd_burst_q || s_resp_bits[83:80] == CMD_READ_LAST)) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, owner, hold flag and error registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= {IDX_W{1'b0}};
      lock_q     <= 1'b0;
      rd_burst_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      rd_burst_q <= rd_burst_d;
      err_q      <= err_d;
    end
  end

  assign s_req_valid  = s_req_valid_s & ~reset;
  assign m_req_ready  = m_req_ready_s & {N_MASTERS{~reset}};
  assign m_resp_valid = m_resp_valid_s & {N_MASTERS{~reset}};
  assign s_resp_ready = s_resp_ready_s & ~reset;
  assign s_req_bits   = sel_bits_s;
  assign m_resp_bits  = {N_MASTERS{s_resp_bits}};
  assign err          = err_q;
endmodule

// File: tb/tb_simplebus_arbiter.sv
// Directed and randomized bench for simplebus_arbiter against a transaction-level reference model.
module tb_simplebus_arbiter;
  localparam int N = 2;
`ifdef SIMPLEBUS_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif
  localparam logic [3:0] C_READ = 4'b0000, C_WRITE = 4'b0001, C_RB = 4'b0010, C_WB = 4'b0011;
  localparam logic [3:0] C_PF = 4'b0100, C_WRESP = 4'b0101, C_RL = 4'b0110, C_WL = 4'b0111;
  localparam logic [3:0] C_PROBE = 4'b1000;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     m_req_valid, m_req_ready, m_resp_valid, m_resp_ready;
  logic [N*127-1:0] m_req_bits;
  logic [N*84-1:0]  m_resp_bits;
  logic             s_req_valid, s_req_ready, s_resp_valid, s_resp_ready, err;
  logic [126:0]     s_req_bits;
  logic [83:0]      s_resp_bits;

  always #5 clock = ~clock;

  simplebus_arbiter #(.N_MASTERS(N)) dut (
    .clock(clock), .reset(reset),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_bits(m_req_bits),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_bits(m_resp_bits),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_bits(s_req_bits),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp_bits(s_resp_bits),
    .err(err)
  );

  int vectors = 0;
  int miscompares = 0;
  // Reference model: phase 0 = no transaction, 1 = write beats, 2 = awaiting response.
  int ph = 0, own = 0, ptr_m = 0, hold = 0, burst = 0;
  bit err_m = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [126:0] mk_req(input logic [3:0] cmd, input logic [15:0] user);
    return {16'h8000, user, 3'd3, cmd, 8'hFF, user, user, user, user, user};
  endfunction

  function automatic logic [83:0] mk_resp(input logic [3:0] cmd, input logic [63:0] rdata);
    return {cmd, rdata, 16'h00AA};
  endfunction

  function automatic bit vbit(input int i);
    return ((m_req_valid >> i) & 2'b01) != 2'b00;
  endfunction

  function automatic logic [126:0] req_of(input int i);
    return 127'(m_req_bits >> (i * 127));
  endfunction

  function automatic int exp_grant();
    int start;
    if (ph != 0 || hold != 0) return own;
    start = RR_BUILD ? ptr_m : 0;
    for (int k = 0; k < N; k++) if (vbit((start + k) % N)) return (start + k) % N;
    return start;
  endfunction

  task automatic eval();
    int g;
    logic [N-1:0] rdy, mrv;
    bit rr;
    #2;
    g = exp_grant();
    chk("m_resp_bits", m_resp_bits, {N{s_resp_bits}});
    if (reset) begin
      chk("rst_s_req_valid", s_req_valid, 1'b0);
      chk("rst_m_req_ready", m_req_ready, {N{1'b0}});
      chk("rst_m_resp_valid", m_resp_valid, {N{1'b0}});
      chk("rst_s_resp_ready", s_resp_ready, 1'b0);
      chk("rst_err", err, 1'b0);
    end else begin
      chk("s_req_valid", s_req_valid, (ph != 2) && vbit(g));
      rdy = (ph != 2) ? (N'(s_req_ready) << g) : {N{1'b0}};
      chk("m_req_ready", m_req_ready & m_req_valid, rdy & m_req_valid);
      if (ph != 2 && vbit(g)) chk("s_req_bits", s_req_bits, req_of(g));
      mrv = (ph == 2) ? (N'(s_resp_valid) << own) : {N{1'b0}};
      chk("m_resp_valid", m_resp_valid, mrv);
      rr = ((m_resp_ready >> own) & 2'b01) != 2'b00;
      chk("s_resp_ready", s_resp_ready, (ph == 2) ? rr : 1'b1);
      chk("err", err, err_m);
    end
  endtask

  task automatic adv();
    int g;
    bit acc, hs;
    logic [126:0] rq;
    logic [3:0] c;
    g  = exp_grant();
    rq = req_of(g);
    c  = rq[91:88];
    if (reset) begin
      ph = 0; own = 0; ptr_m = 0; hold = 0; burst = 0; err_m = 1'b0;
    end else begin
      acc = (ph != 2) && vbit(g) && s_req_ready;
      hs  = (ph == 2) && s_resp_valid && (((m_resp_ready >> own) & 2'b01) != 2'b00);
      if (ph != 2 && s_resp_valid) err_m = 1'b1;
      if (ph == 0) begin
        if (acc) begin
          own = g; hold = 0; ptr_m = (g + 1) % N; burst = (c == C_RB);
          if (c == C_WB) ph = 1;
          else if (c inside {C_READ, C_RB, C_PF, C_PROBE, C_WRITE}) ph = 2;
        end else if (vbit(g)) begin
          own = g; hold = 1;
        end
      end else if (ph == 1) begin
        if (acc && c == C_WL) ph = 2;
      end else if (hs && (burst == 0 || s_resp_bits[83:80] == C_RL)) begin
        ph = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int eo;
    logic [83:0] slot;
    logic [3:0] tbl [6];
    logic [3:0] c0, c1, rc;
    tbl = '{C_READ, C_WRITE, C_RB, C_WB, C_PF, C_PROBE};
    reset = 1'b1; m_req_valid = 2'b00; m_req_bits = '0; m_resp_ready = 2'b00;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp_bits = 84'd0;
    #1;
    // Reset holds every handshake output low even with traffic present.
    m_req_valid = 2'b11; m_req_bits = {mk_req(C_READ, 16'h0011), mk_req(C_READ, 16'h0010)};
    s_req_ready = 1'b1; s_resp_valid = 1'b1;
    eval(); adv(); eval(); adv();
    reset = 1'b0; s_resp_valid = 1'b0; m_resp_ready = 2'b11;

    // Both masters keep requesting READs: RR alternates, fixed priority starves m1.
    for (int t = 0; t < 4; t++) begin
      eo = (RR_BUILD && (t % 2 == 1)) ? 1 : 0;
      s_resp_valid = 1'b0;
      eval(); chk("grant_seq", m_req_ready, (eo == 1) ? 2'b10 : 2'b01); adv();
      s_resp_valid = 1'b1; s_resp_bits = mk_resp(C_RL, 64'hDEADBEEF_00000001);
      eval(); chk("resp_owner", m_resp_valid, (eo == 1) ? 2'b10 : 2'b01);
      slot = 84'(m_resp_bits >> (eo * 84));
      chk("resp_rdata", slot[79:16], 64'hDEADBEEF_00000001);
      adv();
    end
    s_resp_valid = 1'b0;

    // m1 write burst: held while stalled, m0 locked out until the write response.
    m_req_valid = 2'b10; m_req_bits = {mk_req(C_WB, 16'h0101), mk_req(C_READ, 16'h0100)};
    s_req_ready = 1'b0;
    eval(); adv();
    m_req_valid = 2'b11; s_req_ready = 1'b1;
    eval(); chk("wr_m0_blocked", m_req_ready[0], 1'b0); chk("wr_m1_granted", m_req_ready[1], 1'b1); adv();
    m_req_bits = {mk_req(C_WB, 16'h0102), mk_req(C_READ, 16'h0100)};
    eval(); chk("wr_beat2_m0", m_req_ready[0], 1'b0); adv();
    m_req_bits = {mk_req(C_WL, 16'h0103), mk_req(C_READ, 16'h0100)};
    eval(); chk("wr_last_m0", m_req_ready[0], 1'b0); adv();
    s_resp_valid = 1'b1; s_resp_bits = mk_resp(C_WRESP, 64'h0); m_resp_ready = 2'b01;
    eval(); chk("wr_resp_stall", s_resp_ready, 1'b0); chk("wr_wait_m0", m_req_ready[0], 1'b0); adv();
    m_resp_ready = 2'b11;
    eval(); chk("wr_resp_m1", m_resp_valid, 2'b10); adv();
    s_resp_valid = 1'b0;
    eval(); chk("m0_after_write", m_req_ready, 2'b01); adv();
    s_resp_valid = 1'b1; s_resp_bits = mk_resp(C_RL, 64'h1);
    eval(); adv();

    // m0 read burst: three READ_BURST responses keep the transaction open, READ_LAST ends it.
    m_req_valid = 2'b01; m_req_bits = {mk_req(C_READ, 16'h0201), mk_req(C_RB, 16'h0200)};
    s_resp_valid = 1'b0;
    eval(); adv();
    m_req_valid = 2'b11; s_resp_valid = 1'b1; s_resp_bits = mk_resp(C_RB, 64'h10); m_resp_ready = 2'b10;
    for (int k = 0; k < 2; k++) begin
      eval(); chk("burst_stall", s_resp_ready, 1'b0); chk("burst_no_grant", m_req_ready, 2'b00); adv();
    end
    m_resp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      s_resp_bits = mk_resp((k < 3) ? C_RB : C_RL, 64'h20 + 64'(k));
      eval(); chk("burst_wait", m_req_ready, 2'b00); chk("burst_resp_m0", m_resp_valid, 2'b01); adv();
    end
    s_resp_valid = 1'b0; s_req_ready = 1'b0;
    eval(); chk("burst_done_idle", s_req_valid, 1'b1); adv();

    // Stray response with nothing in flight: dropped, sticky err.
    m_req_valid = 2'b00; s_resp_valid = 1'b1; s_resp_bits = mk_resp(C_RL, 64'h5);
    eval(); chk("stray_no_valid", m_resp_valid, 2'b00); chk("stray_ready", s_resp_ready, 1'b1); adv();
    s_resp_valid = 1'b0;
    eval(); chk("err_set", err, 1'b1); adv();
    eval(); chk("err_sticky", err, 1'b1); adv();

    // Reset in the middle of a write burst, then both masters request.
    s_req_ready = 1'b1; m_req_valid = 2'b11;
    m_req_bits = {mk_req(C_WB, 16'h0301), mk_req(C_WB, 16'h0300)};
    eval(); adv();
    eval(); adv();
    reset = 1'b1;
    eval(); chk("midburst_rst_sreq", s_req_valid, 1'b0); chk("midburst_rst_err", err, 1'b0); adv();
    reset = 1'b0; m_req_bits = {mk_req(C_READ, 16'h0311), mk_req(C_READ, 16'h0310)};
    eval(); chk("post_reset_grant", m_req_ready, 2'b01); adv();
    s_resp_valid = 1'b1; s_resp_bits = mk_resp(C_RL, 64'h6);
    eval(); adv();

    // Randomized traffic; the slave only responds while a transaction awaits its response.
    for (int i = 0; i < 800; i++) begin
      m_req_valid = N'($urandom_range(0, 3));
      c0 = (ph == 1) ? (($urandom_range(0, 2) == 0) ? C_WL : C_WB) : tbl[$urandom_range(0, 5)];
      c1 = (ph == 1) ? (($urandom_range(0, 2) == 0) ? C_WL : C_WB) : tbl[$urandom_range(0, 5)];
      m_req_bits = {mk_req(c1, 16'($urandom)), mk_req(c0, 16'($urandom))};
      s_req_ready = ($urandom_range(0, 3) != 0);
      s_resp_valid = (ph == 2) && ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0:       rc = C_RB;
        1:       rc = C_RL;
        default: rc = C_WRESP;
      endcase
      s_resp_bits = mk_resp(rc, {$urandom, $urandom});
      m_resp_ready = N'($urandom_range(0, 3)) | N'($urandom_range(0, 3));
      eval(); adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
